// File: rtl/trans_layer_pkg.sv
// rtl/trans_layer_pkg.sv - shared state encoding, lane count and default widths for the lane reader
package trans_layer_pkg;

    localparam int NUM_LANES     = 4;
    localparam int LANE_W        = 2;
    localparam int DEF_DATA_SIZE = 12;
    localparam int DEF_CONT_SIZE = 5;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-way round-robin grant, search starts one past the last granted lane
module rr_arbiter4
    import trans_layer_pkg::*;
(
    input  logic [NUM_LANES-1:0] request,
    input  logic [LANE_W-1:0]    pointer,
    output logic [NUM_LANES-1:0] grant
);

    logic [LANE_W-1:0] lane;
    logic              found;

    // The 2-bit lane index wraps naturally, so i==4 revisits the pointer lane last.
    always_comb begin
        grant = '0;
        found = 1'b0;
        lane  = '0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            lane = pointer + LANE_W'(i);
            if (!found && request[lane]) begin
                grant[lane] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trans_layer_reader.sv
// rtl/trans_layer_reader.sv - merges four FWFT lane FIFOs into one stream with per-lane word counters
module trans_layer_reader
    import trans_layer_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int CONT_SIZE = DEF_CONT_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [DATA_SIZE-1:0] data_in0,
    input  logic [DATA_SIZE-1:0] data_in1,
    input  logic [DATA_SIZE-1:0] data_in2,
    input  logic [DATA_SIZE-1:0] data_in3,
    input  logic [NUM_LANES-1:0] empty,
    output logic                 pop0,
    output logic                 pop1,
    output logic                 pop2,
    output logic                 pop3,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready,
    input  logic                 req,
    input  logic [2:0]           idx,
    output logic [CONT_SIZE-1:0] data_out_cont,
    output logic                 valid_cont,
    output logic                 idle
);

    state_t                state, state_nxt;
    logic                  pop_en;
    logic [NUM_LANES-1:0]  grant;
    logic [LANE_W-1:0]     ptr;
    logic [LANE_W-1:0]     grant_idx;
    logic [DATA_SIZE-1:0]  lane_data [NUM_LANES];
    logic [DATA_SIZE-1:0]  sel_data;
    logic [CONT_SIZE-1:0]  cnt [NUM_LANES];

    assign lane_data[0] = data_in0;
    assign lane_data[1] = data_in1;
    assign lane_data[2] = data_in2;
    assign lane_data[3] = data_in3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_RESET;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop_en    = 1'b0;
        idle      = 1'b0;
        case (state)
            ST_RESET:  state_nxt = init ? ST_INIT : ST_ACTIVE;
            ST_INIT:   if (!init) state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
                if (init) state_nxt = ST_INIT;
                pop_en = !valid_out || ready;
                idle   = (&empty) && !valid_out;
            end
            default:   state_nxt = ST_RESET;
        endcase
    end

    rr_arbiter4 u_arb (
        .request (~empty & {NUM_LANES{pop_en}}),
        .pointer (ptr),
        .grant   (grant)
    );

    assign pop0 = grant[0];
    assign pop1 = grant[1];
    assign pop2 = grant[2];
    assign pop3 = grant[3];

    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (grant[k]) grant_idx = LANE_W'(k);
        end
        sel_data = lane_data[grant_idx];
    end

    // Counter readout samples the pre-pop value because both use the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out      <= '0;
            valid_out     <= 1'b0;
            ptr           <= LANE_W'(NUM_LANES - 1);
            data_out_cont <= '0;
            valid_cont    <= 1'b0;
            for (int k = 0; k < NUM_LANES; k++) cnt[k] <= '0;
        end else begin
            if (state == ST_INIT) begin
                valid_out <= 1'b0;
                for (int k = 0; k < NUM_LANES; k++) cnt[k] <= '0;
            end else if (|grant) begin
                data_out       <= sel_data;
                valid_out      <= 1'b1;
                ptr            <= grant_idx;
                cnt[grant_idx] <= cnt[grant_idx] + CONT_SIZE'(1);
            end else if (ready) begin
                valid_out <= 1'b0;
            end

            if (state == ST_ACTIVE && req && !idx[2]) begin
                data_out_cont <= cnt[idx[1:0]];
                valid_cont    <= 1'b1;
            end else begin
                data_out_cont <= '0;
                valid_cont    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trans_layer_reader.sv
// tb/tb_trans_layer_reader.sv - randomized and directed bench for trans_layer_reader
module tb_trans_layer_reader;

    localparam int M_RST = 0;
    localparam int M_INI = 1;
    localparam int M_ACT = 2;

    logic        clk = 1'b0;
    logic        reset, init, ready, req;
    logic [2:0]  idx;
    logic [11:0] din [4];
    logic [3:0]  empty;
    logic        pop0, pop1, pop2, pop3;
    logic [11:0] data_out;
    logic        valid_out, valid_cont, idle;
    logic [4:0]  data_out_cont;
    logic [3:0]  pops;

    logic [11:0] q [4][$];
    logic [3:0]  pop_seen = '0;
    bit          started = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    int          m_mode = M_RST;
    bit          m_valid = 1'b0;
    logic [11:0] m_data = '0;
    int          m_ptr = 3;
    int          m_cnt [4] = '{0, 0, 0, 0};
    bit          m_cv = 1'b0;
    int          m_cd = 0;

    assign pops = {pop3, pop2, pop1, pop0};

    always #5 clk = ~clk;

    trans_layer_reader dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .data_in0      (din[0]),
        .data_in1      (din[1]),
        .data_in2      (din[2]),
        .data_in3      (din[3]),
        .empty         (empty),
        .pop0          (pop0),
        .pop1          (pop1),
        .pop2          (pop2),
        .pop3          (pop3),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .ready         (ready),
        .req           (req),
        .idx           (idx),
        .data_out_cont (data_out_cont),
        .valid_cont    (valid_cont),
        .idle          (idle)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lane that must be popped this cycle, or -1.
    function automatic int pick();
        if (m_mode != M_ACT || (m_valid && !ready)) return -1;
        for (int j = 1; j <= 4; j++) begin
            int l;
            l = (m_ptr + j) % 4;
            if (!empty[l]) return l;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = M_RST; m_valid = 0; m_data = '0; m_ptr = 3;
            m_cv = 0; m_cd = 0;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        end else begin
            int  l, ncd;
            bit  ncv;
            l = pick();
            ncv = (m_mode == M_ACT) && req && (idx < 4);
            ncd = ncv ? m_cnt[idx[1:0]] : 0;
            if (m_mode == M_INI) begin
                m_valid = 0;
                for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            end else if (l >= 0) begin
                m_data = din[l];
                m_valid = 1;
                m_ptr = l;
                m_cnt[l] = (m_cnt[l] + 1) % 32;
            end else if (ready) begin
                m_valid = 0;
            end
            m_cv = ncv;
            m_cd = ncd;
            case (m_mode)
                M_RST:   m_mode = init ? M_INI : M_ACT;
                M_INI:   if (!init) m_mode = M_ACT;
                default: if (init) m_mode = M_INI;
            endcase
        end
    end

    always @(negedge clk) begin
        pop_seen = pops;
        if (started) begin
            int l;
            l = pick();
            chk("pops", pops, (l < 0) ? 0 : (1 << l));
            chk("valid_out", valid_out, m_valid);
            chk("data_out", data_out, m_data);
            chk("idle", idle, (m_mode == M_ACT) && (empty == 4'hF) && !m_valid);
            chk("valid_cont", valid_cont, m_cv);
            chk("data_out_cont", data_out_cont, m_cd);
        end
    end

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            empty[k] = (q[k].size() == 0);
            din[k] = empty[k] ? 12'($urandom) : q[k][0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++)
            if (pop_seen[k] && q[k].size() > 0) void'(q[k].pop_front());
        drive();
    endtask

    task automatic init_pulse();
        init = 1; drive();
        tick(); tick();
        init = 0; drive();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; init = 1; ready = 1; req = 0; idx = 0;
        for (int k = 0; k < 4; k++) q[k].push_back(12'h0F0 + 12'(k) * 12'h100);
        drive();
        tick(); tick();
        started = 1;
        @(negedge clk);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_pops", pops, 0);
        chk("rst_idle", idle, 0);
        tick();
        reset = 0;
        repeat (3) begin
            @(negedge clk);
            chk("init_pops", pops, 0);
            chk("init_valid_out", valid_out, 0);
            tick();
        end
        init = 0; drive();
        tick();
        @(negedge clk);
        chk("first_pop_lane0", pops, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("rr_sequence", data_out, 12'h0F0 + 12'(i) * 12'h100);
        end

        tick(); tick();
        ready = 0;
        for (int k = 0; k < 4; k++) q[k].push_back(12'hA00 + 12'(k));
        drive();
        @(negedge clk);
        chk("stall_first_pop", pops, 4'b0001);
        tick();
        repeat (5) begin
            @(negedge clk);
            chk("stall_data", data_out, 12'hA00);
            chk("stall_no_pop", pops, 0);
            tick();
        end
        ready = 1; drive();
        @(negedge clk);
        chk("resume_pop1", pops, 4'b0010);
        tick();
        @(negedge clk);
        chk("resume_data", data_out, 12'hA01);
        repeat (8) tick();

        init_pulse();
        for (int i = 0; i < 33; i++) q[2].push_back(12'($urandom));
        drive();
        for (int i = 0; i < 80 && q[2].size() != 0; i++) tick();
        chk("lane2_drained", q[2].size(), 0);
        tick();
        req = 1; idx = 3'd2; drive();
        tick();
        @(negedge clk);
        chk("cont_lane2", data_out_cont, 5'd1);
        chk("cont_lane2_valid", valid_cont, 1);
        idx = 3'd7;
        tick();
        @(negedge clk);
        chk("cont_idx7_valid", valid_cont, 0);
        chk("cont_idx7_data", data_out_cont, 0);
        req = 0;

        init_pulse();
        for (int i = 0; i < 4; i++) q[1].push_back(12'h500 + 12'(i));
        drive();
        repeat (4) begin
            @(negedge clk);
            chk("lane1_pop", pops, 4'b0010);
            tick();
        end
        tick();
        req = 1; idx = 3'd1; drive();
        @(negedge clk);
        chk("lane1_idle", idle, 1);
        tick();
        @(negedge clk);
        chk("cont_lane1", data_out_cont, 5'd4);
        req = 0;

        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 6; i++) q[k].push_back(12'($urandom));
        drive();
        tick(); tick(); tick();
        reset = 1;
        #1;
        chk("midrst_valid_out", valid_out, 0);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_pops", pops, 0);
        chk("midrst_idle", idle, 0);
        chk("midrst_valid_cont", valid_cont, 0);
        tick();
        reset = 0; drive();
        tick();
        @(negedge clk);
        chk("midrst_restart_lane0", pops, 4'b0001);

        repeat (3000) begin
            tick();
            ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 2) == 0 && q[k].size() < 6) q[k].push_back(12'($urandom));
            req = $urandom_range(0, 1) == 1;
            idx = 3'($urandom);
            init = ($urandom_range(0, 99) == 0) || (init && $urandom_range(0, 1) == 1);
            reset = ($urandom_range(0, 299) == 0);
            drive();
        end
        reset = 0; init = 0; drive();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
